// File: rtl/st_pkg.sv
// st_pkg: shared store funct3 codes, write FSM states and store-buffer entry type
package st_pkg;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
  } st_entry_t;
endpackage

// File: rtl/st_fifo.sv
// st_fifo: DEPTH-entry store buffer with push/pop and full/empty flags
module st_fifo
  import st_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  st_entry_t din,
  output st_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  st_entry_t mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  end
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
endmodule

// File: rtl/st_write_unit.sv
// st_write_unit: buffered SB/SH/SW store writer with lane formatting; ST_MISALIGN_SPLIT_EN enables two-beat misaligned stores
module st_write_unit
  import st_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st_valid_i,
  output logic        st_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  output logic        busy_o,
  output logic        illegal_o,
  output logic        misalign_err_o
);
  st_entry_t in_entry, fifo_dout, head;
  state_t state, nxt;
  logic full, empty, accept, legal, push, pop, req, illegal_q;
  logic [1:0] off;
  logic [3:0] base_be, b0_be;
  logic [31:0] b0_addr, b0_data;
  assign st_ready_o = !full && !rst_i;
  assign accept = st_valid_i && st_ready_o;
  assign legal = funct3_i inside {F3_SB, F3_SH, F3_SW};
  assign in_entry = '{funct3: funct3_i, addr: addr_i, data: data_i};
  assign head = empty ? in_entry : fifo_dout;
  assign off = head.addr[1:0];
  assign base_be = head.funct3 == F3_SB ? 4'b0001 : head.funct3 == F3_SH ? 4'b0011 : 4'b1111;
  assign b0_addr = {head.addr[31:2], 2'b00};
`ifdef ST_MISALIGN_SPLIT_EN
  logic [63:0] wide_data;
  logic [7:0] wide_be;
  logic [3:0] b1_be;
  logic split;
  assign push = accept && legal;
  assign wide_data = head.funct3 == F3_SB ? {32'b0, {4{head.data[7:0]}}}
                   : {32'b0, head.funct3 == F3_SH ? {16'b0, head.data[15:0]} : head.data} << {off, 3'b000};
  assign wide_be = {4'b0000, base_be} << off;
  assign b0_data = wide_data[31:0];
  assign b0_be = wide_be[3:0];
  assign b1_be = wide_be[7:4];
  assign split = |b1_be;
  assign misalign_err_o = 1'b0;
`else
  logic misalign, misalign_q;
  assign misalign = (funct3_i == F3_SH && addr_i[1:0] == 2'b11) || (funct3_i == F3_SW && addr_i[1:0] != 2'b00);
  assign push = accept && legal && !misalign;
  assign b0_data = head.funct3 == F3_SB ? {4{head.data[7:0]}}
                 : head.funct3 == F3_SH ? {16'b0, head.data[15:0]} << {off, 3'b000} : head.data;
  assign b0_be = base_be << off;
  assign misalign_err_o = misalign_q && !rst_i;
`endif
  st_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .pop(pop),
    .din(in_entry),
    .dout(fifo_dout),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = (!empty || push) ? BEAT0 : IDLE;
`ifdef ST_MISALIGN_SPLIT_EN
      BEAT0: nxt = mem_ack_i ? (split ? BEAT1 : IDLE) : BEAT0;
      BEAT1: nxt = mem_ack_i ? IDLE : BEAT1;
`else
      BEAT0: nxt = mem_ack_i ? IDLE : BEAT0;
`endif
      default: nxt = IDLE;
    endcase
  end
  assign pop = state != IDLE && nxt == IDLE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      req <= 1'b0;
      illegal_q <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      mem_be_o <= '0;
`ifndef ST_MISALIGN_SPLIT_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state <= nxt;
      req <= nxt != IDLE;
      illegal_q <= accept && !legal;
`ifndef ST_MISALIGN_SPLIT_EN
      misalign_q <= accept && legal && misalign;
`endif
      if (state == IDLE && nxt == BEAT0) begin
        mem_addr_o <= b0_addr;
        mem_wdata_o <= b0_data;
        mem_be_o <= b0_be;
      end
`ifdef ST_MISALIGN_SPLIT_EN
      else if (state == BEAT0 && nxt == BEAT1) begin
        mem_addr_o <= {head.addr[31:2] + 30'd1, 2'b00};
        mem_wdata_o <= wide_data[63:32];
        mem_be_o <= b1_be;
      end
`endif
    end
  end
  assign mem_req_o = req && !rst_i;
  assign illegal_o = illegal_q && !rst_i;
  assign busy_o = !empty || state != IDLE;
endmodule
